// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the bounded random value generator.
// Holds the controller state encoding and the range-mask helper.
package lfsr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StCheck,
        StOut
    } state_e;

    // Smallest all-ones value covering n-1; n=0 wraps to 0xFFFF (full 16-bit range).
    function automatic logic [15:0] range_mask(input logic [15:0] n);
        logic [15:0] v;
        v = n - 16'd1;
        v = v | (v >> 1);
        v = v | (v >> 2);
        v = v | (v >> 4);
        v = v | (v >> 8);
        return v;
    endfunction

endpackage

// File: rtl/lfsr_range.sv
// Bounded random value generator: masks an external LFSR value into [0, N-1]
// by rejection sampling, with a subtract fallback and reseed after too many rejects.
module lfsr_range
    import lfsr_pkg::*;
#(
    parameter int unsigned GP_MAX_RETRY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] range,
    input  logic [15:0] lfsr,
    output logic        gen_en,
    output logic        rgen_trg,
    output logic [15:0] rnd,
    output logic        rnd_vld,
    input  logic        rnd_rdy,
    output logic        busy
);

    localparam logic [7:0] LastRetry = 8'(GP_MAX_RETRY - 1);

    state_e      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [7:0]  retry_q, retry_d;
    logic [15:0] rnd_q, rnd_d;

    logic [15:0] mask;
    logic [15:0] cand;
    logic        accept;
    logic        fallback;

    always_comb begin
        mask = range_mask(n_q);
        cand = lfsr & mask;
        // N=0 encodes 65536, so every candidate fits
        accept = (n_q == 16'd0) || (cand < n_q);
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        retry_d  = retry_q;
        rnd_d    = rnd_q;
        fallback = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    n_d     = range;
                    retry_d = 8'd0;
                    state_d = StStep;
                end
            end
            StStep: begin
                state_d = StCheck;
            end
            StCheck: begin
                if (accept) begin
                    rnd_d   = cand;
                    state_d = StOut;
                end else if (retry_q != LastRetry) begin
                    retry_d = retry_q + 8'd1;
                    state_d = StStep;
                end else begin
                    // cand < 2*N here, so the difference is always in range
                    rnd_d    = cand - n_q;
                    fallback = 1'b1;
                    state_d  = StOut;
                end
            end
            StOut: begin
                if (rnd_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= 16'd0;
            retry_q <= 8'd0;
            rnd_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            retry_q <= retry_d;
            rnd_q   <= rnd_d;
        end
    end

    // Gated by rst so a pending request emits no pulse while reset is held
    always_comb begin
        gen_en   = !rst && (state_q == StStep);
        rgen_trg = !rst && fallback;
        rnd_vld  = !rst && (state_q == StOut);
        busy     = !rst && (state_q != StIdle);
        rnd      = rnd_q;
    end

endmodule

// File: tb/tb_lfsr_range.sv
// Self-checking bench for lfsr_range: directed cases plus randomized requests
// compared against a rejection-sampling reference model.
module tb_lfsr_range;

    localparam int unsigned MaxRetry = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [15:0] range_v;
    logic [15:0] lfsr_v;
    logic        gen_en;
    logic        rgen_trg;
    logic [15:0] rnd;
    logic        rnd_vld;
    logic        rnd_rdy;
    logic        busy;

    logic        req2;
    logic [15:0] range2;
    logic [15:0] lfsr2;
    logic        gen_en2;
    logic        rgen_trg2;
    logic [15:0] rnd2;
    logic        rnd_vld2;
    logic        rnd_rdy2;
    logic        busy2;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] seq[$];

    always #5 clk = ~clk;

    lfsr_range #(.GP_MAX_RETRY(MaxRetry)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .range    (range_v),
        .lfsr     (lfsr_v),
        .gen_en   (gen_en),
        .rgen_trg (rgen_trg),
        .rnd      (rnd),
        .rnd_vld  (rnd_vld),
        .rnd_rdy  (rnd_rdy),
        .busy     (busy)
    );

    lfsr_range #(.GP_MAX_RETRY(2)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .req      (req2),
        .range    (range2),
        .lfsr     (lfsr2),
        .gen_en   (gen_en2),
        .rgen_trg (rgen_trg2),
        .rnd      (rnd2),
        .rnd_vld  (rnd_vld2),
        .rnd_rdy  (rnd_rdy2),
        .busy     (busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: draw values in order, keep the first one that fits under the mask,
    // otherwise fold the last allowed draw down by N and request a reseed.
    function automatic void model(input logic [15:0] n, input int unsigned max_retry,
                                  output logic [15:0] r, output int k, output int trg);
        int nn;
        int msk;
        int c;
        nn  = (n == 16'd0) ? 65536 : int'(n);
        msk = 0;
        while (msk < nn - 1) msk = msk * 2 + 1;
        trg = 0;
        r   = 16'd0;
        k   = -1;
        for (int i = 0; i < seq.size(); i++) begin
            c = int'(seq[i]) & msk;
            if (c < nn) begin
                r = 16'(c);
                k = i;
                return;
            end
            if (i == int'(max_retry) - 1) begin
                r   = 16'(c - nn);
                k   = i;
                trg = 1;
                return;
            end
        end
    endfunction

    task automatic run_txn(input string tag, input logic [15:0] n, input int hold);
        logic [15:0] er;
        logic [15:0] held;
        logic [15:0] q[$];
        int ek;
        int etrg;
        int gcnt;
        int tcnt;
        int vcyc;
        int c;
        bit pend;
        model(n, MaxRetry, er, ek, etrg);
        q    = seq;
        gcnt = 0;
        tcnt = 0;
        vcyc = -1;
        c    = 0;
        pend = 1'b0;
        @(posedge clk);
        #1;
        range_v = n;
        req     = 1'b1;
        while (c < 200 && vcyc < 0) begin
            @(negedge clk);
            if (gen_en) begin
                gcnt++;
                pend = 1'b1;
            end
            if (rgen_trg) tcnt++;
            if (rnd_vld) begin
                vcyc = c;
            end else begin
                @(posedge clk);
                #1;
                c++;
                req = 1'b0;
                if (pend) begin
                    lfsr_v = (q.size() > 0) ? q.pop_front() : 16'($urandom);
                    pend   = 1'b0;
                end
            end
        end
        req = 1'b0;
        check({tag, "/vld_cycle"}, 32'(vcyc), 32'(3 + 2 * ek));
        check({tag, "/gen_pulses"}, 32'(gcnt), 32'(ek + 1));
        check({tag, "/rgen_pulses"}, 32'(tcnt), 32'(etrg));
        check({tag, "/rnd"}, 32'(rnd), 32'(er));
        held = rnd;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            req    = ~req;
            lfsr_v = 16'($urandom);
            @(negedge clk);
            check({tag, "/hold_rnd"}, 32'(rnd), 32'(held));
            check({tag, "/hold_vld"}, 32'(rnd_vld), 32'd1);
            check({tag, "/hold_gen"}, 32'(gen_en), 32'd0);
        end
        @(posedge clk);
        #1;
        req     = 1'b0;
        rnd_rdy = 1'b1;
        @(posedge clk);
        #1;
        rnd_rdy = 1'b0;
        @(negedge clk);
        check({tag, "/idle_busy"}, 32'(busy), 32'd0);
        check({tag, "/idle_vld"}, 32'(rnd_vld), 32'd0);
    endtask

    initial begin
        int gc;
        int tc;
        int vc;
        logic [15:0] n;

        rst      = 1'b1;
        req      = 1'b0;
        range_v  = 16'd0;
        lfsr_v   = 16'd0;
        rnd_rdy  = 1'b0;
        req2     = 1'b0;
        range2   = 16'd0;
        lfsr2    = 16'h0007;
        rnd_rdy2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/gen_en", 32'(gen_en), 32'd0);
        check("reset/rgen_trg", 32'(rgen_trg), 32'd0);
        check("reset/rnd_vld", 32'(rnd_vld), 32'd0);
        check("reset/rnd", 32'(rnd), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        seq = '{16'h0003};
        run_txn("n6_first", 16'd6, 0);
        seq = '{16'h0007, 16'h0006, 16'h0002};
        run_txn("n6_two_rej", 16'd6, 1);
        seq = '{16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007};
        run_txn("n5_fallback", 16'd5, 0);
        seq = '{16'hBEEF};
        run_txn("n0_full", 16'd0, 0);
        seq = '{16'hFFFF};
        run_txn("n1_zero", 16'd1, 0);
        seq = '{16'h0001};
        run_txn("hold10", 16'd6, 10);

        // Reset while sitting in CHECK on a rejected draw
        @(posedge clk);
        #1;
        range_v = 16'd6;
        req     = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        lfsr_v = 16'h0007;
        rst    = 1'b1;
        @(negedge clk);
        check("rst_mid/gen_en", 32'(gen_en), 32'd0);
        check("rst_mid/rgen_trg", 32'(rgen_trg), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid/busy", 32'(busy), 32'd0);
        check("rst_mid/rnd_vld", 32'(rnd_vld), 32'd0);
        check("rst_mid/rnd", 32'(rnd), 32'd0);
        check("rst_mid/gen_after", 32'(gen_en), 32'd0);
        seq = '{16'h0004};
        run_txn("after_rst", 16'd6, 0);

        // Two-retry instance with a stuck generator value
        @(posedge clk);
        #1;
        range2 = 16'd5;
        req2   = 1'b1;
        gc = 0;
        tc = 0;
        vc = -1;
        for (int c = 0; c < 50 && vc < 0; c++) begin
            @(negedge clk);
            if (gen_en2) gc++;
            if (rgen_trg2) tc++;
            if (rnd_vld2) vc = c;
            @(posedge clk);
            #1;
            req2 = 1'b0;
        end
        check("retry2/gen_pulses", 32'(gc), 32'd2);
        check("retry2/rgen_pulses", 32'(tc), 32'd1);
        check("retry2/vld_cycle", 32'(vc), 32'd5);
        check("retry2/rnd", 32'(rnd2), 32'd2);
        rnd_rdy2 = 1'b1;
        @(posedge clk);
        #1;
        rnd_rdy2 = 1'b0;
        @(negedge clk);
        check("retry2/idle", 32'(busy2), 32'd0);

        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 3))
                0:       n = 16'($urandom);
                1:       n = 16'($urandom_range(0, 20));
                2:       n = 16'((1 << $urandom_range(0, 14)) + 1);
                default: n = 16'($urandom_range(1, 300));
            endcase
            seq.delete();
            for (int i = 0; i < 10; i++) seq.push_back(16'($urandom));
            run_txn($sformatf("rand%0d", t), n, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_range.md
LFSR_RANGE -- requirements
Module: lfsr_range

Interface
REQ-001 SHALL have parameter GP_MAX_RETRY, default 8, the consecutive rejections that force fallback (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port req, input, 1, request one bounded random value.
REQ-005 SHALL have port range, input, 16, upper bound N; result is in [0, N-1]; N=0 means 65536.
REQ-006 SHALL have port lfsr, input, 16, current generator value; it updates the cycle after gen_en.
REQ-007 SHALL have port gen_en, output, 1, one-cycle generator step request.
REQ-008 SHALL have port rgen_trg, output, 1, one-cycle reseed trigger to the generator.
REQ-009 SHALL have port rnd, output, 16, bounded result.
REQ-010 SHALL have port rnd_vld, output, 1, result valid.
REQ-011 SHALL have port rnd_rdy, input, 1, consumer accepts the result.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, STEP, CHECK and OUT.
REQ-014 IDLE with req=1 SHALL latch range into N_q, clear retry_cnt and go to STEP; req SHALL be ignored in every other state.
REQ-015 STEP SHALL assert gen_en for exactly that cycle and go to CHECK.
REQ-016 CHECK SHALL compute mask as the smallest all-ones value that is >= N_q-1, and form cand = lfsr & mask.
REQ-017 For N_q=0, mask SHALL be 0xFFFF and every cand SHALL be accepted; for N_q=1, mask SHALL be 0 and rnd SHALL be 0.
REQ-018 In CHECK, if cand < N_q, the block SHALL register rnd=cand and go to OUT.
REQ-019 In CHECK, if cand >= N_q and retry_cnt < GP_MAX_RETRY-1, the block SHALL increment retry_cnt and go to STEP.
REQ-020 In CHECK, if cand >= N_q and retry_cnt = GP_MAX_RETRY-1, the block SHALL register rnd=cand-N_q, pulse rgen_trg for that one cycle, and go to OUT.
REQ-021 cand-N_q SHALL always be < N_q, because cand < 2*N_q; arithmetic SHALL be 16-bit unsigned with no wrap.
REQ-022 OUT SHALL hold rnd_vld=1 with rnd stable until rnd_rdy=1, then go to IDLE.
REQ-023 If req and rnd_rdy are both high in OUT, the block SHALL return to IDLE; req SHALL be accepted at the earliest in the following cycle.
REQ-024 Best-case latency SHALL be: req sampled in cycle 0, gen_en in cycle 1, rnd_vld in cycle 3; each rejection SHALL add 2 cycles.
REQ-025 rnd SHALL be registered; gen_en, rgen_trg and rnd_vld SHALL be glitch-free state-decoded outputs.

Reset
REQ-026 While rst=1, the block SHALL force state IDLE, N_q=0, retry_cnt=0, rnd=0, rnd_vld=0, gen_en=0, rgen_trg=0 and busy=0.
REQ-027 Reset asserted mid-operation SHALL abandon the request with no further gen_en or rgen_trg pulse.

Structure
REQ-028 The state enum and a range_mask function (16-bit OR-smear of N-1) SHALL reside in the shared package lfsr_pkg.
REQ-029 No sub-module is required; the block SHALL be a single FSM plus datapath registers.

Verification
REQ-030 N=6, lfsr driven 0x0003 after the step -> exactly one gen_en pulse, rnd=3, rnd_vld in cycle 3.
REQ-031 N=6, lfsr sequence 0x0007, 0x0006, 0x0002 -> three gen_en pulses, rnd=2, rnd_vld in cycle 7, no rgen_trg.
REQ-032 GP_MAX_RETRY=2, N=5, lfsr always 0x0007 -> two gen_en pulses, one rgen_trg pulse, rnd=2.
REQ-033 N=0 with lfsr 0xBEEF -> rnd=0xBEEF; N=1 with lfsr 0xFFFF -> rnd=0.
REQ-034 rnd_rdy held low 10 cycles with req toggling -> rnd stable, rnd_vld=1, no gen_en.
REQ-035 rst pulsed during CHECK -> next cycle IDLE with all outputs 0; a new req then completes normally.
